// File: rtl/fb_combiner.sv
// ---------------------------------------------------------------------------
// fb_combiner
//
// Feedback-output combiner. Sums N_CH gain-scaled channel products plus a
// static offset at full precision, saturates the result to the DAC width and
// drives the DAC word through a three-register pipeline:
//   S1 (_p0) sum + upstream overflow OR + mode tag
//   S2 (_p1) clamp + event overflow
//   S3       output register (fb_sgnl / fb_valid / oflow)
// Slow-domain configuration is synchronised and only copied into the active
// registers between bunch trains (store_strb low).
//
// Ports
//   clk, rst      : feedback clock, asynchronous active-high reset
//   store_strb    : bunch train gate; low forces fb_sgnl to 0 and flushes
//   fb_cond       : ch_data / ch_oflow valid strobe
//   ch_data       : N_CH packed signed products, channel k at [k*IN_W +: IN_W]
//   ch_oflow      : per-channel upstream overflow flags
//   offset_b      : signed static offset (slow domain)
//   const_val_b   : constant DAC word (slow domain)
//   mode_b        : 0 off, 1 feedback, 2 constant, 3 off (slow domain)
//   oflow_clr     : clears sticky flag and counter
//   fb_sgnl       : registered signed DAC word
//   fb_valid      : pulse when fb_sgnl is loaded from an event
//   oflow         : pulse with fb_valid when that event overflowed
//   oflow_sticky  : set by any oflow
//   oflow_count   : overflowed events, saturating at 255
// ---------------------------------------------------------------------------
module fb_combiner #(
    parameter int N_CH        = 4,
    parameter int IN_W        = 15,
    parameter int OUT_W       = 13,
    parameter int SYNC_STAGES = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     store_strb,
    input  logic                     fb_cond,
    input  logic [N_CH*IN_W-1:0]     ch_data,
    input  logic [N_CH-1:0]          ch_oflow,
    input  logic [OUT_W-1:0]         offset_b,
    input  logic [OUT_W-1:0]         const_val_b,
    input  logic [1:0]               mode_b,
    input  logic                     oflow_clr,
    output logic signed [OUT_W-1:0]  fb_sgnl,
    output logic                     fb_valid,
    output logic                     oflow,
    output logic                     oflow_sticky,
    output logic [7:0]               oflow_count
);

    // Sum width grows by clog2(N_CH+1) to hold N_CH products plus the offset.
    localparam int SW = IN_W + $clog2(N_CH + 1);
    localparam int MAX_I = 2 ** (OUT_W - 1) - 1;
    localparam logic signed [SW-1:0] SAT_MAX = SW'(MAX_I);
    localparam logic signed [SW-1:0] SAT_MIN = SW'(-MAX_I - 1);

    function automatic logic signed [SW-1:0] sext_in(input logic [IN_W-1:0] x);
        return {{(SW - IN_W){x[IN_W-1]}}, x};
    endfunction

    function automatic logic signed [SW-1:0] sext_out(input logic [OUT_W-1:0] x);
        return {{(SW - OUT_W){x[OUT_W-1]}}, x};
    endfunction

    function automatic logic out_of_range(input logic signed [SW-1:0] x);
        return (x > SAT_MAX) || (x < SAT_MIN);
    endfunction

    function automatic logic signed [OUT_W-1:0] saturate(input logic signed [SW-1:0] x);
        if (x > SAT_MAX)
            return SAT_MAX[OUT_W-1:0];
        else if (x < SAT_MIN)
            return SAT_MIN[OUT_W-1:0];
        else
            return x[OUT_W-1:0];
    endfunction

    // Slow-domain synchronisers
    (* ASYNC_REG = "TRUE", SHREG_EXTRACT = "NO" *) logic [OUT_W-1:0] offset_sync [SYNC_STAGES];
    (* ASYNC_REG = "TRUE", SHREG_EXTRACT = "NO" *) logic [OUT_W-1:0] const_sync  [SYNC_STAGES];
    (* ASYNC_REG = "TRUE", SHREG_EXTRACT = "NO" *) logic [1:0]       mode_sync   [SYNC_STAGES];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                offset_sync[i] <= '0;
                const_sync[i]  <= '0;
                mode_sync[i]   <= '0;
            end
        end else begin
            offset_sync[0] <= offset_b;
            const_sync[0]  <= const_val_b;
            mode_sync[0]   <= mode_b;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                offset_sync[i] <= offset_sync[i-1];
                const_sync[i]  <= const_sync[i-1];
                mode_sync[i]   <= mode_sync[i-1];
            end
        end
    end

    // Active configuration only follows the synchronisers between trains.
    logic signed [OUT_W-1:0] act_offset;
    logic signed [OUT_W-1:0] act_const;
    logic [1:0]              act_mode;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            act_offset <= '0;
            act_const  <= '0;
            act_mode   <= '0;
        end else if (!store_strb) begin
            act_offset <= offset_sync[SYNC_STAGES-1];
            act_const  <= const_sync[SYNC_STAGES-1];
            act_mode   <= mode_sync[SYNC_STAGES-1];
        end
    end

    logic signed [SW-1:0] sum_c;

    always_comb begin
        sum_c = sext_out(act_offset);
        for (int k = 0; k < N_CH; k++)
            sum_c = sum_c + sext_in(ch_data[k*IN_W +: IN_W]);
    end

    // Valids: store_strb low drops everything in flight.
    logic vld_p0;
    logic vld_p1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p0 <= 1'b0;
            vld_p1 <= 1'b0;
        end else begin
            vld_p0 <= store_strb & fb_cond;
            vld_p1 <= store_strb & vld_p0;
        end
    end

    // ---- S1: full-precision sum, upstream overflow, mode tag ----
    logic signed [SW-1:0] sum_p0;
    logic                 uof_p0;
    logic [1:0]           mode_p0;

    always_ff @(posedge clk) begin
        sum_p0  <= sum_c;
        uof_p0  <= |ch_oflow;
        mode_p0 <= act_mode;
    end

    // ---- S2: clamp and event overflow ----
    logic signed [OUT_W-1:0] sat_p1;
    logic                    evof_p1;
    logic [1:0]              mode_p1;

    always_ff @(posedge clk) begin
        sat_p1  <= saturate(sum_p0);
        evof_p1 <= out_of_range(sum_p0) | uof_p0;
        mode_p1 <= mode_p0;
    end

    // ---- S3: output register ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fb_sgnl  <= '0;
            fb_valid <= 1'b0;
            oflow    <= 1'b0;
        end else if (!store_strb) begin
            fb_sgnl  <= '0;
            fb_valid <= 1'b0;
            oflow    <= 1'b0;
        end else if (vld_p1) begin
            case (mode_p1)
                2'd1: begin
                    fb_sgnl  <= sat_p1;
                    fb_valid <= 1'b1;
                    oflow    <= evof_p1;
                end
                2'd2: begin
                    fb_sgnl  <= act_const;
                    fb_valid <= 1'b1;
                    oflow    <= 1'b0;
                end
                default: begin
                    fb_sgnl  <= '0;
                    fb_valid <= 1'b0;
                    oflow    <= 1'b0;
                end
            endcase
        end else begin
            fb_valid <= 1'b0;
            oflow    <= 1'b0;
        end
    end

    // Sticky / counter follow the registered oflow pulse; a clear in the
    // same cycle as a pulse leaves that pulse counted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            oflow_sticky <= 1'b0;
            oflow_count  <= '0;
        end else if (oflow_clr) begin
            oflow_sticky <= oflow;
            oflow_count  <= oflow ? 8'd1 : 8'd0;
        end else if (oflow) begin
            oflow_sticky <= 1'b1;
            if (oflow_count != 8'd255)
                oflow_count <= oflow_count + 8'd1;
        end
    end

endmodule

// File: tb/tb_fb_combiner.sv
// Scoreboard bench for fb_combiner with default parameters.
module tb_fb_combiner;

    logic                clk = 1'b0;
    logic                rst;
    logic                store_strb;
    logic                fb_cond;
    logic [59:0]         ch_data;
    logic [3:0]          ch_oflow;
    logic [12:0]         offset_b;
    logic [12:0]         const_val_b;
    logic [1:0]          mode_b;
    logic                oflow_clr;
    logic signed [12:0]  fb_sgnl;
    logic                fb_valid;
    logic                oflow;
    logic                oflow_sticky;
    logic [7:0]          oflow_count;

    always #5 clk = ~clk;

    fb_combiner dut (
        .clk          (clk),
        .rst          (rst),
        .store_strb   (store_strb),
        .fb_cond      (fb_cond),
        .ch_data      (ch_data),
        .ch_oflow     (ch_oflow),
        .offset_b     (offset_b),
        .const_val_b  (const_val_b),
        .mode_b       (mode_b),
        .oflow_clr    (oflow_clr),
        .fb_sgnl      (fb_sgnl),
        .fb_valid     (fb_valid),
        .oflow        (oflow),
        .oflow_sticky (oflow_sticky),
        .oflow_count  (oflow_count)
    );

    typedef struct packed {
        logic signed [12:0] v;
        logic               o;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int total = 0;
    int bad   = 0;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, req);
        end
    endtask

    function automatic logic [59:0] pk(input int a, input int b, input int c, input int d);
        return {15'(d), 15'(c), 15'(b), 15'(a)};
    endfunction

    // Drive one fb_cond cycle; optionally record the expected output event.
    task automatic issue(input int a, input int b, input int c, input int d,
                         input logic [3:0] of, input int ev, input logic eo, input bit push);
        exp_t e;
        ch_data  = pk(a, b, c, d);
        ch_oflow = of;
        fb_cond  = 1'b1;
        if (push) begin
            e.v = 13'(ev);
            e.o = eo;
            q.push_back(e);
        end
        step();
        fb_cond  = 1'b0;
        ch_oflow = '0;
    endtask

    task automatic cfg(input int m, input int off, input int cv);
        mode_b      = 2'(m);
        offset_b    = 13'(off);
        const_val_b = 13'(cv);
        store_strb  = 1'b0;
        repeat (5) step();
        store_strb  = 1'b1;
    endtask

    // Monitor: every fb_valid pulse must match the oldest expected event.
    always @(negedge clk) begin
        if (!rst && fb_valid) begin
            total++;
            if (q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_valid: fb_sgnl=%0d oflow=%0d with no event pending", fb_sgnl, oflow);
            end else begin
                mon_e = q.pop_front();
                if (fb_sgnl !== mon_e.v || oflow !== mon_e.o) begin
                    bad++;
                    $display("FAIL event: got fb_sgnl=%0d oflow=%0d want fb_sgnl=%0d oflow=%0d",
                             fb_sgnl, oflow, mon_e.v, mon_e.o);
                end
            end
        end
    end

    initial begin
        rst = 1'b1; store_strb = 1'b0; fb_cond = 1'b0; ch_data = '0; ch_oflow = '0;
        offset_b = '0; const_val_b = '0; mode_b = '0; oflow_clr = 1'b0;
        repeat (3) step();
        check("rst_sgnl", fb_sgnl, 0);
        check("rst_valid", fb_valid, 0);
        check("rst_oflow", oflow, 0);
        check("rst_sticky", oflow_sticky, 0);
        check("rst_count", oflow_count, 0);
        rst = 1'b0;
        step();

        // Active mode is 0 after reset: event produces nothing.
        store_strb = 1'b1;
        issue(100, -50, 25, 5, 4'b0, 0, 1'b0, 1'b0);
        repeat (4) step();
        check("mode0_sgnl", fb_sgnl, 0);

        cfg(1, 0, 0);

        // Basic sum with latency check.
        issue(100, -50, 25, 5, 4'b0, 80, 1'b0, 1'b1);
        step();
        check("latency_early", fb_valid, 0);
        step();
        check("latency_valid", fb_valid, 1);
        check("basic_sgnl", fb_sgnl, 80);
        repeat (3) step();
        check("hold_sgnl", fb_sgnl, 80);

        // Saturation both ways, back to back.
        issue(4000, 4000, 0, 0, 4'b0, 4095, 1'b1, 1'b1);
        issue(-4000, -4000, -4000, -4000, 4'b0, -4096, 1'b1, 1'b1);
        repeat (5) step();
        check("sat_sticky", oflow_sticky, 1);
        check("sat_count", oflow_count, 2);
        check("sat_neg_hold", fb_sgnl, -4096);

        // Upstream flag alone flags the event.
        issue(1, 2, 3, 4, 4'b0100, 10, 1'b1, 1'b1);
        repeat (5) step();
        check("upstream_count", oflow_count, 3);

        // Offset change mid-train is not applied until store_strb drops.
        offset_b = 13'(-10);
        repeat (4) step();
        issue(1, 1, 1, 1, 4'b0, 4, 1'b0, 1'b1);
        repeat (4) step();
        store_strb = 1'b0;
        repeat (4) step();
        check("strb_low_zero", fb_sgnl, 0);
        store_strb = 1'b1;
        issue(1, 1, 1, 1, 4'b0, -6, 1'b0, 1'b1);
        repeat (4) step();
        check("offset_applied", fb_sgnl, -6);

        // Constant mode ignores overflow.
        cfg(2, -10, 1234);
        issue(0, 0, 0, 0, 4'b0001, 1234, 1'b0, 1'b1);
        issue(4000, 4000, 0, 0, 4'b0, 1234, 1'b0, 1'b1);
        repeat (4) step();
        check("const_count", oflow_count, 3);

        // Abort: store_strb falls one cycle after fb_cond.
        issue(5, 5, 5, 5, 4'b0, 0, 1'b0, 1'b0);
        store_strb = 1'b0;
        step();
        check("abort_zero", fb_sgnl, 0);
        repeat (4) step();
        store_strb = 1'b1;

        // Plain clear.
        oflow_clr = 1'b1;
        step();
        oflow_clr = 1'b0;
        check("clr_count", oflow_count, 0);
        check("clr_sticky", oflow_sticky, 0);

        // Counter saturation at 255.
        cfg(1, -10, 0);
        for (int i = 0; i < 260; i++)
            issue(0, 0, 0, 0, 4'b0001, -10, 1'b1, 1'b1);
        repeat (6) step();
        check("count_sat", oflow_count, 255);
        check("count_sat_sticky", oflow_sticky, 1);

        // Clear coincident with an oflow pulse.
        issue(0, 0, 0, 0, 4'b0001, -10, 1'b1, 1'b1);
        step();
        step();
        check("coinc_oflow", oflow, 1);
        oflow_clr = 1'b1;
        step();
        oflow_clr = 1'b0;
        check("coinc_count", oflow_count, 1);
        check("coinc_sticky", oflow_sticky, 1);

        // Reset one cycle after fb_cond.
        issue(7, 7, 7, 7, 4'b0, 0, 1'b0, 1'b0);
        rst = 1'b1;
        #1;
        check("midrst_sgnl", fb_sgnl, 0);
        check("midrst_valid", fb_valid, 0);
        check("midrst_sticky", oflow_sticky, 0);
        check("midrst_count", oflow_count, 0);
        step();
        step();
        rst = 1'b0;
        repeat (6) step();

        // Normal operation after reset.
        cfg(1, 0, 0);
        issue(1, 1, 1, 1, 4'b0, 4, 1'b0, 1'b1);
        repeat (5) step();
        check("post_rst_sgnl", fb_sgnl, 4);

        check("queue_drained", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fb_combiner.md
# fb_combiner

Parametrised feedback-output combiner, successor to the four-channel fixed-width summing stage at the end of the feedback path. It takes `N_CH` gain-scaled position products from the DSP stages and adds a configurable static offset. The result is saturated, not wrapped, to the DAC width. It drives the DAC word with a fixed pipeline latency and supports off, feedback and constant-DAC modes. Overflow is reported per event and as a sticky, counted status for the slow-control readback.

## Interface
Parameters:
- `N_CH`, 4, number of channel products summed (2..8)
- `IN_W`, 15, signed width of each channel product
- `OUT_W`, 13, signed DAC word width (`OUT_W` <= `IN_W`)
- `SYNC_STAGES`, 2, synchroniser depth for slow-domain control inputs

Ports (clock and reset first):
- `clk` in 1: feedback clock; all logic on its rising edge
- `rst` in 1: asynchronous, active-high reset
- `store_strb` in 1: high during the bunch train; low forces the output to zero
- `fb_cond` in 1: one-cycle strobe marking that `ch_data`/`ch_oflow` are valid this cycle
- `ch_data` in `N_CH*IN_W`: packed signed products, channel k at bits [k*IN_W +: IN_W]
- `ch_oflow` in `N_CH`: per-channel upstream overflow flags, qualified by `fb_cond`
- `offset_b` in `OUT_W`: signed static offset (banana correction), slow domain
- `const_val_b` in `OUT_W`: constant DAC word, slow domain
- `mode_b` in 2: slow domain; 0 = off, 1 = feedback, 2 = constant, 3 = reserved (behaves as off)
- `oflow_clr` in 1: clk-domain pulse; clears sticky flag and counter
- `fb_sgnl` out `OUT_W`: registered signed DAC word (IOB register)
- `fb_valid` out 1: one-cycle pulse when `fb_sgnl` is loaded from an event
- `oflow` out 1: one-cycle pulse, coincident with `fb_valid`, when that event overflowed
- `oflow_sticky` out 1: set by any `oflow`
- `oflow_count` out 8: number of overflowed events, saturating at 255

## Operation
- `offset_b`, `const_val_b` and `mode_b` pass through `SYNC_STAGES` flops each (no SRL extraction, ASYNC_REG).
- The synchronised values are copied into active registers only on cycles with `store_strb` low, so configuration never changes mid-train.
- S1, on `fb_cond` with `store_strb` high:
  - Register the full-precision sum `SW = IN_W + clog2(N_CH+1)` bits of all channels plus the sign-extended active offset.
  - Register the OR of `ch_oflow`.
  - Tag the event with the active mode.
- S2: compare the sum against [-2^(OUT_W-1), 2^(OUT_W-1)-1].
  - Clamp to the nearest limit when out of range.
  - `ev_oflow` = out-of-range OR the upstream flag.
- S3, output register:
  - Mode 1: load the clamped sum.
  - Mode 2: load the active `const_val`; `ev_oflow` is forced 0.
  - Mode 0/3: load 0; no `fb_valid` pulse.
  - Modes 1 and 2 pulse `fb_valid`; `oflow` = `ev_oflow`.
- `fb_sgnl` holds its value between events.
- `store_strb` low:
  - `fb_sgnl` goes to 0 on the next edge.
  - All in-flight pipeline valids are cleared, so no event issued before the falling edge reaches the output.
- `fb_cond` is ignored while `store_strb` is low.
- Sticky and counter:
  - `oflow` sets `oflow_sticky` and increments `oflow_count` (holding at 255).
  - `oflow_clr` clears both. When `oflow_clr` and `oflow` occur in the same cycle, the result is sticky = 1, count = 1.

## Timing
- Reset values: `fb_sgnl` = 0, `fb_valid` = 0, `oflow` = 0, `oflow_sticky` = 0, `oflow_count` = 0, all pipeline valids 0, active mode = 0, active offset/const = 0, synchroniser flops 0.
- Latency: `fb_cond` at edge n gives `fb_sgnl`/`fb_valid`/`oflow` at edge n+3, independent of `N_CH`.
- Throughput: one event per cycle; back-to-back `fb_cond` yields consecutive `fb_valid` pulses.
- Config latency: a `*_b` change is visible in the active registers `SYNC_STAGES`+1 edges later, provided `store_strb` is low throughout.
- Reset asserted mid-pipeline: all state returns to reset values immediately. The first event after deassertion follows the normal 3-cycle latency.
- Arithmetic: all sums are signed. No wrap-around anywhere. The clamp output is exactly 2^(OUT_W-1)-1 or -2^(OUT_W-1).

## Test plan
- Defaults, mode 1, offset 0, `store_strb` high: `ch_data` = {100, -50, 25, 5} with `fb_cond` at edge n -> `fb_sgnl` = 80 and `fb_valid` = 1 at edge n+3, `oflow` = 0; `fb_sgnl` holds 80 afterwards.
- Saturation: {4000, 4000, 0, 0}, offset 0 -> `fb_sgnl` = 4095 with `oflow` pulse. Then {-4000, -4000, -4000, -4000} -> -4096, `oflow` again; `oflow_sticky` = 1, `oflow_count` = 2.
- Offset and config gating: set `offset_b` = -10 while `store_strb` high -> events still use offset 0. Drop `store_strb` for 4 cycles and re-raise; event {1, 1, 1, 1} -> `fb_sgnl` = -6.
- Constant mode: `mode_b` = 2, `const_val_b` = 1234 (loaded while `store_strb` low); any `fb_cond` -> `fb_sgnl` = 1234, `oflow` = 0 even with `ch_oflow` = 4'b0001.
- Abort and clear: `fb_cond` at n, `store_strb` falls at n+1 -> no `fb_valid`, `fb_sgnl` = 0 from n+2. With count = 255, an overflowing event keeps count at 255. `oflow_clr` coincident with `oflow` -> count = 1, sticky = 1.
- Reset: assert `rst` one cycle after a `fb_cond` in mode 1 -> all outputs 0 immediately; no `fb_valid` appears after release.
